// File: rtl/ipsxe_fft_frame_gen_pkg.sv
// Shared definitions for the FFT test-frame generator: width derivation,
// FSM encoding and configuration-beat bit positions.
package ipsxe_fft_frame_gen_pkg;

  localparam int FWD_INV_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  function automatic int datain_byte_num(input int input_width);
    return (input_width + 7) / 8;
  endfunction

  function automatic int datain_width(input int input_width);
    return 8 * datain_byte_num(input_width);
  endfunction

endpackage

// File: rtl/ipsxe_fft_frame_gen_src_rom.sv
// Registered sample ROM: word = {imag, real}; real = sample index, imag is
// the index for forward frames and its negation for inverse frames.
module ipsxe_fft_src_rom
  import ipsxe_fft_frame_gen_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int INPUT_WIDTH  = 16,
  parameter int DATAIN_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_clken,
  input  logic                      i_rstn,
  input  logic [ADDR_W-1:0]         i_addr,
  output logic [2*DATAIN_WIDTH-1:0] o_rdata
);

  function automatic logic [2*DATAIN_WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] addr);
    logic [INPUT_WIDTH-1:0] re;
    logic [INPUT_WIDTH-1:0] im;
    re = INPUT_WIDTH'(addr[ADDR_W-2:0]);
    im = addr[ADDR_W-1] ? re : (~re + INPUT_WIDTH'(1));
    return {DATAIN_WIDTH'($signed(im)), DATAIN_WIDTH'($signed(re))};
  endfunction

  // Read port; address is presented one cycle ahead of use.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rdata <= '0;
    end else if (i_clken) begin
      o_rdata <= rom_word(i_addr);
    end
  end

endmodule

// File: rtl/ipsxe_fft_frame_gen.sv
// FFT test-frame generator: one config beat (FFT/IFFT alternating) followed by
// one frame of samples, repeated TEST_FRAME_NUM times per start pulse.
module ipsxe_fft_frame_gen
  import ipsxe_fft_frame_gen_pkg::*;
#(
  parameter int TEST_FRAME_NUM    = 10,
  parameter int LOG2_FFT_LEN      = 4,
  parameter int INPUT_WIDTH       = 16,
  parameter int FRAME_GAP         = 0,
  parameter int FRAME_GEN_DATA_EN = 0,
  localparam int DATAIN_WIDTH     = datain_width(INPUT_WIDTH)
) (
  input  logic                      i_aclk,
  input  logic                      i_aresetn,
  input  logic                      i_aclken,
  input  logic                      i_start_test,
  output logic                      o_gen_finished,
  output logic                      o_axi4s_cfg_tvalid,
  output logic [7:0]                o_axi4s_cfg_tdata,
  input  logic                      i_axi4s_cfg_tready,
  output logic                      o_axi4s_data_tvalid,
  output logic [2*DATAIN_WIDTH-1:0] o_axi4s_data_tdata,
  output logic                      o_axi4s_data_tlast,
  input  logic                      i_axi4s_data_tready
);

  localparam int FRM_W = clog2(TEST_FRAME_NUM);
  localparam int GAP_W = (FRAME_GAP > 1) ? clog2(FRAME_GAP) : 1;
  localparam logic [LOG2_FFT_LEN-1:0] SMP_LAST = {LOG2_FFT_LEN{1'b1}};
  localparam logic [FRM_W-1:0]        FRM_LAST = FRM_W'(TEST_FRAME_NUM - 1);
  localparam logic [GAP_W-1:0]        GAP_LAST = GAP_W'(FRAME_GAP - 1);

  state_t                    state_r, state_s;
  logic [FRM_W-1:0]          frm_cnt_r, frm_cnt_s;
  logic [LOG2_FFT_LEN-1:0]   smp_cnt_r, smp_cnt_s;
  logic [GAP_W-1:0]          gap_cnt_r, gap_cnt_s;
  logic                      finished_r, finished_s;
  logic                      cfg_tvalid_r, cfg_tvalid_s;
  logic [7:0]                cfg_tdata_r, cfg_tdata_s;
  logic                      data_tvalid_r, data_tvalid_s;
  logic                      data_tlast_r, data_tlast_s;
  logic [2*DATAIN_WIDTH-1:0] data_tdata_r;
  logic [2*DATAIN_WIDTH-1:0] cnt_tdata_s;
  logic [INPUT_WIDTH-1:0]    re_s, im_s;
  logic                      cfg_acc_s, data_acc_s, data_load_s;

  assign cfg_acc_s   = cfg_tvalid_r & i_axi4s_cfg_tready;
  assign data_acc_s  = data_tvalid_r & i_axi4s_data_tready;
  // Sample register refills whenever the output slot is empty or being drained.
  assign data_load_s = i_aclken & (~data_tvalid_r | i_axi4s_data_tready);

  assign re_s        = INPUT_WIDTH'(smp_cnt_s);
  assign im_s        = INPUT_WIDTH'(frm_cnt_s);
  assign cnt_tdata_s = {DATAIN_WIDTH'($signed(im_s)), DATAIN_WIDTH'($signed(re_s))};

  // Next-state and next-output logic.
  always_comb begin
    state_s       = state_r;
    frm_cnt_s     = frm_cnt_r;
    smp_cnt_s     = smp_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    finished_s    = finished_r;
    cfg_tvalid_s  = cfg_tvalid_r;
    cfg_tdata_s   = cfg_tdata_r;
    data_tvalid_s = data_tvalid_r;
    data_tlast_s  = data_tlast_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start_test) begin
          state_s      = ST_CFG;
          frm_cnt_s    = '0;
          smp_cnt_s    = '0;
          finished_s   = 1'b0;
          cfg_tvalid_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CFG: begin
        if (cfg_acc_s) begin
          state_s       = ST_DATA;
          cfg_tvalid_s  = 1'b0;
          data_tvalid_s = 1'b1;
          data_tlast_s  = (smp_cnt_r == SMP_LAST);
        end else begin
          state_s = ST_CFG;
        end
      end
      ST_DATA: begin
        if (data_acc_s && data_tlast_r) begin
          smp_cnt_s     = '0;
          data_tvalid_s = 1'b0;
          data_tlast_s  = 1'b0;
          if (frm_cnt_r == FRM_LAST) begin
            state_s    = ST_IDLE;
            finished_s = 1'b1;
          end else begin
            frm_cnt_s = frm_cnt_r + FRM_W'(1);
            if (FRAME_GAP > 0) begin
              state_s   = ST_GAP;
              gap_cnt_s = '0;
            end else begin
              state_s      = ST_CFG;
              cfg_tvalid_s = 1'b1;
            end
          end
        end else if (data_acc_s) begin
          smp_cnt_s    = smp_cnt_r + LOG2_FFT_LEN'(1);
          data_tlast_s = (smp_cnt_s == SMP_LAST);
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s      = ST_CFG;
          gap_cnt_s    = '0;
          cfg_tvalid_s = 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_W'(1);
        end
      end
      default: begin
        state_s       = ST_IDLE;
        finished_s    = 1'b1;
        cfg_tvalid_s  = 1'b0;
        data_tvalid_s = 1'b0;
        data_tlast_s  = 1'b0;
      end
    endcase
    // Config payload is latched only as the beat is raised so it stays stable.
    if (cfg_tvalid_s && !cfg_tvalid_r) begin
      cfg_tdata_s              = 8'h00;
      cfg_tdata_s[FWD_INV_BIT] = ~frm_cnt_s[0];
    end else begin
      cfg_tdata_s = cfg_tdata_r;
    end
  end

  // State and output registers, frozen while the clock enable is low.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_r       <= ST_IDLE;
      frm_cnt_r     <= '0;
      smp_cnt_r     <= '0;
      gap_cnt_r     <= '0;
      finished_r    <= 1'b1;
      cfg_tvalid_r  <= 1'b0;
      cfg_tdata_r   <= 8'h00;
      data_tvalid_r <= 1'b0;
      data_tlast_r  <= 1'b0;
    end else if (i_aclken) begin
      state_r       <= state_s;
      frm_cnt_r     <= frm_cnt_s;
      smp_cnt_r     <= smp_cnt_s;
      gap_cnt_r     <= gap_cnt_s;
      finished_r    <= finished_s;
      cfg_tvalid_r  <= cfg_tvalid_s;
      cfg_tdata_r   <= cfg_tdata_s;
      data_tvalid_r <= data_tvalid_s;
      data_tlast_r  <= data_tlast_s;
    end
  end

  if (FRAME_GEN_DATA_EN == 1) begin : g_rom
    logic [LOG2_FFT_LEN:0] rom_addr_s;
    assign rom_addr_s = {~frm_cnt_s[0], smp_cnt_s};
    ipsxe_fft_src_rom #(
      .ADDR_W       (LOG2_FFT_LEN + 1),
      .INPUT_WIDTH  (INPUT_WIDTH),
      .DATAIN_WIDTH (DATAIN_WIDTH)
    ) u_src_rom (
      .i_clk   (i_aclk),
      .i_clken (data_load_s),
      .i_rstn  (i_aresetn),
      .i_addr  (rom_addr_s),
      .o_rdata (data_tdata_r)
    );
  end else begin : g_cnt
    // Counter pattern register: {frame index, sample index}.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
        data_tdata_r <= '0;
      end else if (data_load_s) begin
        data_tdata_r <= cnt_tdata_s;
      end
    end
  end

  assign o_gen_finished      = finished_r;
  assign o_axi4s_cfg_tvalid  = cfg_tvalid_r;
  assign o_axi4s_cfg_tdata   = cfg_tdata_r;
  assign o_axi4s_data_tvalid = data_tvalid_r;
  assign o_axi4s_data_tdata  = data_tdata_r;
  assign o_axi4s_data_tlast  = data_tlast_r;

endmodule

// File: tb/tb_ipsxe_fft_frame_gen.sv
// Scoreboard bench: two generators (frame gap 0 and 3) share stimulus; a
// reference beat list is queued per run and a monitor checks every transfer.
module tb_ipsxe_fft_frame_gen;

  localparam int N_FRM = 10;
  localparam int LEN   = 16;
  localparam int GAP0  = 0;
  localparam int GAP1  = 3;

  logic clk = 1'b0;
  logic rst_n, start, en, cfg_rdy, data_rdy;
  logic [1:0] fin, cfg_v, data_v, last;
  logic [1:0][7:0]  cfg_d;
  logic [1:0][31:0] data_d;
  bit rnd_data, rnd_cfg, rnd_en, cfg_hold;

  typedef struct packed {
    logic        is_cfg;
    logic        last;
    logic        final_b;
    logic [31:0] val;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ipsxe_fft_frame_gen #(.FRAME_GAP(GAP0)) dut0 (
    .i_aclk(clk), .i_aresetn(rst_n), .i_aclken(en), .i_start_test(start),
    .o_gen_finished(fin[0]), .o_axi4s_cfg_tvalid(cfg_v[0]), .o_axi4s_cfg_tdata(cfg_d[0]),
    .i_axi4s_cfg_tready(cfg_rdy), .o_axi4s_data_tvalid(data_v[0]),
    .o_axi4s_data_tdata(data_d[0]), .o_axi4s_data_tlast(last[0]),
    .i_axi4s_data_tready(data_rdy));

  ipsxe_fft_frame_gen #(.FRAME_GAP(GAP1)) dut1 (
    .i_aclk(clk), .i_aresetn(rst_n), .i_aclken(en), .i_start_test(start),
    .o_gen_finished(fin[1]), .o_axi4s_cfg_tvalid(cfg_v[1]), .o_axi4s_cfg_tdata(cfg_d[1]),
    .i_axi4s_cfg_tready(cfg_rdy), .o_axi4s_data_tvalid(data_v[1]),
    .o_axi4s_data_tdata(data_d[1]), .o_axi4s_data_tlast(last[1]),
    .i_axi4s_data_tready(data_rdy));

  task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int qsize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t qpop(int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Reference beat list for one full run.
  task automatic push_run();
    beat_t b;
    for (int f = 0; f < N_FRM; f++) begin
      b = '{is_cfg: 1'b1, last: 1'b0, final_b: 1'b0, val: (f % 2 == 0) ? 32'd1 : 32'd0};
      q0.push_back(b); q1.push_back(b);
      for (int s = 0; s < LEN; s++) begin
        b = '{is_cfg: 1'b0, last: (s == LEN - 1), final_b: (s == LEN - 1) && (f == N_FRM - 1),
              val: {16'(f), 16'(s)}};
        q0.push_back(b); q1.push_back(b);
      end
    end
  endtask

  // Monitor state
  bit   prev_en;
  bit   cstall[2], dstall[2], dnext[2], fpend[2], gpend[2];
  int   gcnt[2];
  logic [7:0]  p_cd[2];
  logic [31:0] p_dd[2];
  logic        p_last[2];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        cstall[k] = 0; dstall[k] = 0; dnext[k] = 0; fpend[k] = 0; gpend[k] = 0; gcnt[k] = 0;
      end
      prev_en = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        beat_t b;
        int gap;
        gap = (k == 0) ? GAP0 : GAP1;
        if (cstall[k]) begin
          check("cfg_stall_valid", k, cfg_v[k], 1);
          check("cfg_stall_data", k, cfg_d[k], p_cd[k]);
        end
        if (dstall[k]) begin
          check("data_stall_valid", k, data_v[k], 1);
          check("data_stall_data", k, data_d[k], p_dd[k]);
          check("data_stall_last", k, last[k], p_last[k]);
        end
        if (dnext[k]) begin
          check("data_no_bubble", k, data_v[k], 1);
          dnext[k] = 0;
        end
        if (fpend[k]) begin
          check("finished_after_last", k, fin[k], 1);
          check("idle_after_last", k, data_v[k], 0);
          fpend[k] = 0;
        end
        if (gpend[k]) begin
          gcnt[k] += int'(prev_en);
          if (cfg_v[k] || gcnt[k] > gap + 1) begin
            check("gap_cycles", k, gcnt[k], gap + 1);
            gpend[k] = 0;
          end
        end
        check("cfg_data_exclusive", k, cfg_v[k] & data_v[k], 0);
        if (en && cfg_v[k] && cfg_rdy) begin
          if (qsize(k) == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_cfg dut%0d: got beat %0h expected none", k, cfg_d[k]);
          end else begin
            b = qpop(k);
            check("beat_kind_cfg", k, b.is_cfg, 1);
            check("cfg_tdata", k, cfg_d[k], b.val);
            dnext[k] = 1;
          end
        end
        if (en && data_v[k] && data_rdy) begin
          if (qsize(k) == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_data dut%0d: got beat %0h expected none", k, data_d[k]);
          end else begin
            b = qpop(k);
            check("beat_kind_data", k, b.is_cfg, 0);
            check("data_tdata", k, data_d[k], b.val);
            check("data_tlast", k, last[k], b.last);
            if (b.final_b) fpend[k] = 1;
            else if (b.last) begin gpend[k] = 1; gcnt[k] = 0; end
            else dnext[k] = 1;
          end
        end
        cstall[k] = cfg_v[k] && !(en && cfg_rdy);
        dstall[k] = data_v[k] && !(en && data_rdy);
        p_cd[k] = cfg_d[k]; p_dd[k] = data_d[k]; p_last[k] = last[k];
      end
      prev_en = en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start    = 1'b0;
    data_rdy = rnd_data ? 1'($urandom_range(0, 1)) : 1'b1;
    cfg_rdy  = cfg_hold ? 1'b0 : (rnd_cfg ? 1'($urandom_range(0, 1)) : 1'b1);
    en       = rnd_en ? ~en : 1'b1;
  endtask

  task automatic chk_reset(string name);
    for (int k = 0; k < 2; k++) begin
      check({name, "_finished"}, k, fin[k], 1);
      check({name, "_cfg_tvalid"}, k, cfg_v[k], 0);
      check({name, "_cfg_tdata"}, k, cfg_d[k], 0);
      check({name, "_data_tvalid"}, k, data_v[k], 0);
      check({name, "_data_tdata"}, k, data_d[k], 0);
      check({name, "_data_tlast"}, k, last[k], 0);
    end
  endtask

  task automatic run_start();
    step();
    start = 1'b1;
    en    = 1'b1;
    push_run();
    step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("start_finished_low", k, fin[k], 0);
      check("start_cfg_valid", k, cfg_v[k], 1);
    end
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 6000; i++) begin
      step();
      if (fin == 2'b11 && q0.size() == 0 && q1.size() == 0) break;
    end
    if (i == 6000) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout: got fin=%b q0=%0d q1=%0d expected finished and empty",
               fin, q0.size(), q1.size());
    end
    repeat (3) step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; en = 1'b1; cfg_rdy = 1'b1; data_rdy = 1'b1;
    #12;
    chk_reset("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) step();

    // Full-rate run.
    run_start();
    wait_done();

    // Random back-pressure with an ignored mid-run start pulse.
    rnd_data = 1; rnd_cfg = 1;
    run_start();
    repeat (60) step();
    start = 1'b1;
    wait_done();

    // Config back-pressure held for 20 cycles.
    rnd_data = 0; rnd_cfg = 0; cfg_hold = 1;
    run_start();
    for (int i = 0; i < 20; i++) begin
      step();
      check("cfg_held_valid", i, cfg_v, 2'b11);
      check("cfg_held_no_data", i, data_v, 2'b00);
    end
    cfg_hold = 0;
    wait_done();

    // Clock enable toggling with random back-pressure.
    rnd_en = 1; rnd_data = 1; rnd_cfg = 1;
    run_start();
    wait_done();
    rnd_en = 0;

    // Reset mid-frame, then a fresh run from frame 0.
    run_start();
    repeat (40) step();
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    q0.delete(); q1.delete();
    step(); step();
    rst_n = 1'b1;
    step();
    run_start();
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
